// File: rtl/dat_mem_pkg.sv
// Shared types for the stack-capable data memory: op encoding, FSM states
// and the default memory depth.
package dat_mem_pkg;

  localparam int DEPTH = 256;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } op_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/dat_mem_ram.sv
// DW x 2**AW storage array: one write port, one registered read port.
// Deliberately unreset so it maps onto block RAM.
module dat_mem_ram #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dat_mem_stk.sv
// Data memory with base+offset load/store and a descending hardware stack
// in the top region; zero-cleared by a sweep after every reset.
module dat_mem_stk
  import dat_mem_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int STK_BASE = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] immed,
  input  logic [DW-1:0] dat_in,
  output logic [DW-1:0] dat_out,
  output logic          rd_valid,
  output logic          busy,
  output logic [AW-1:0] sp,
  output logic          err
);

  if (STK_BASE < 1 || STK_BASE > (2**AW) - 1) begin : g_bad_stk_base
    $error("dat_mem_stk: STK_BASE out of range 1..DEPTH-1");
  end

  state_t        state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic [AW-1:0] sp_q, sp_d;
  logic          rd_valid_q, rd_valid_d;
  logic          err_q, err_d;
  logic          rd_seen_q;

  logic          we, re;
  logic [AW-1:0] waddr, raddr, ea;
  logic [DW-1:0] wdata, rdata;

  assign ea = addr + immed;

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    sp_d       = sp_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    we         = 1'b0;
    waddr      = ea;
    wdata      = dat_in;
    re         = 1'b0;
    raddr      = ea;
    unique case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_q;
        wdata = '0;
        clr_d = clr_q + 1'b1;
        if (clr_q == '1) state_d = READY;
      end
      READY: begin
        case (op_t'(op))
          OP_NOP: ;
          OP_LOAD: begin
            re         = 1'b1;
            rd_valid_d = 1'b1;
          end
          OP_STORE: we = 1'b1;
          OP_PUSH: begin
            if (sp_q == AW'(STK_BASE - 1)) begin
              err_d = 1'b1;
            end else begin
              we    = 1'b1;
              waddr = sp_q;
              sp_d  = sp_q - 1'b1;
            end
          end
          OP_POP: begin
            if (sp_q == '1) begin
              err_d = 1'b1;
            end else begin
              re         = 1'b1;
              raddr      = sp_q + 1'b1;
              rd_valid_d = 1'b1;
              sp_d       = sp_q + 1'b1;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_q      <= '0;
      sp_q       <= '1;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      sp_q       <= sp_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      if (rd_valid_d) rd_seen_q <= 1'b1;
    end
  end

  dat_mem_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  // The RAM read register has no reset; mask it until the first read lands.
  assign dat_out  = rd_seen_q ? rdata : '0;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign busy     = (state_q == CLEAR);
  assign sp       = sp_q;

endmodule

// File: tb/tb_dat_mem_stk.sv
// Directed self-checking bench for dat_mem_stk (default parameters).
module tb_dat_mem_stk;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] op;
  logic [7:0] addr, immed, dat_in;
  logic [7:0] dat_out, sp;
  logic       rd_valid, busy, err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dat_mem_stk dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .addr     (addr),
    .immed    (immed),
    .dat_in   (dat_in),
    .dat_out  (dat_out),
    .rd_valid (rd_valid),
    .busy     (busy),
    .sp       (sp),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [7:0] a, input logic [7:0] im,
                       input logic [7:0] d);
    op = o; addr = a; immed = im; dat_in = d;
  endtask

  // Run the sweep from just after reset release; returns cycles until busy fell
  // and how many cycles showed rd_valid or err while busy.
  task automatic sweep(output int cycles, output int bad);
    cycles = 0;
    bad = 0;
    while (busy && cycles < 400) begin
      tick();
      cycles++;
      if (busy && (rd_valid || err)) bad++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, bad;
    reset = 1'b1;
    drive(3'd1, 8'h10, 8'h00, 8'h00);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_sp", sp, 8'hFF);
    chk("rst_dat_out", dat_out, 8'h00);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_err", err, 0);

    // Sweep with LOAD held on op: must be ignored
    @(posedge clk); #3;
    reset = 1'b0;
    sweep(cyc, bad);
    chk("sweep_cycles", cyc, 256);
    chk("sweep_no_rv_err", bad, 0);
    chk("ready_rv_idle", rd_valid, 0);
    tick();
    chk("first_load_rv", rd_valid, 1);
    chk("first_load_dat", dat_out, 8'h00);

    // STORE with wrapping effective address, LOAD back via different base/offset
    drive(3'd2, 8'hF0, 8'h20, 8'hA5); tick();
    chk("store_rv", rd_valid, 0);
    chk("store_err", err, 0);
    drive(3'd1, 8'h08, 8'h08, 8'h00); tick();
    chk("wrap_load_rv", rd_valid, 1);
    chk("wrap_load_dat", dat_out, 8'hA5);
    drive(3'd0, 8'h00, 8'h00, 8'h00); tick();
    chk("nop_rv", rd_valid, 0);
    chk("nop_dat_hold", dat_out, 8'hA5);

    // Push/pop sequence
    drive(3'd3, 8'h00, 8'h00, 8'h11); tick();
    chk("push1_sp", sp, 8'hFE);
    drive(3'd3, 8'h00, 8'h00, 8'h22); tick();
    chk("push2_sp", sp, 8'hFD);
    drive(3'd4, 8'h00, 8'h00, 8'h00); tick();
    chk("pop1_sp", sp, 8'hFE);
    chk("pop1_dat", dat_out, 8'h22);
    chk("pop1_rv", rd_valid, 1);
    tick();
    chk("pop2_sp", sp, 8'hFF);
    chk("pop2_dat", dat_out, 8'h11);
    chk("pop2_rv", rd_valid, 1);
    tick();
    chk("underflow_err", err, 1);
    chk("underflow_rv", rd_valid, 0);
    chk("underflow_dat", dat_out, 8'h11);
    chk("underflow_sp", sp, 8'hFF);

    // Fill the stack, then overflow
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      drive(3'd3, 8'h00, 8'h00, 8'(i)); tick();
      if (err) bad++;
    end
    chk("fill_no_err", bad, 0);
    chk("fill_sp", sp, 8'h7F);
    drive(3'd3, 8'h00, 8'h00, 8'hEE); tick();
    chk("overflow_err", err, 1);
    chk("overflow_sp", sp, 8'h7F);
    drive(3'd1, 8'h7F, 8'h00, 8'h00); tick();
    chk("below_base_dat", dat_out, 8'h00);
    chk("below_base_rv", rd_valid, 1);
    drive(3'd4, 8'h00, 8'h00, 8'h00); tick();
    chk("top_pop_dat", dat_out, 8'h7F);
    chk("top_pop_sp", sp, 8'h80);

    // Reserved op
    drive(3'd6, 8'h10, 8'h00, 8'h99); tick();
    chk("rsvd_err", err, 1);
    chk("rsvd_rv", rd_valid, 0);
    chk("rsvd_sp", sp, 8'h80);
    drive(3'd0, 8'h00, 8'h00, 8'h00); tick();
    chk("rsvd_err_pulse", err, 0);
    drive(3'd1, 8'h10, 8'h00, 8'h00); tick();
    chk("rsvd_mem_intact", dat_out, 8'hA5);

    // Reset mid-sweep
    drive(3'd2, 8'hC8, 8'h00, 8'h77); tick();
    drive(3'd0, 8'h00, 8'h00, 8'h00); tick();
    drive(3'd1, 8'hC8, 8'h00, 8'h00); tick();
    chk("pre_reset_dat", dat_out, 8'h77);
    drive(3'd0, 8'h00, 8'h00, 8'h00);
    reset = 1'b1; #2;
    reset = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("mid_sweep_busy", busy, 1);
    #2;
    reset = 1'b1; #1;
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_sp", sp, 8'hFF);
    chk("mid_rst_dat", dat_out, 8'h00);
    @(posedge clk); #3;
    reset = 1'b0;
    sweep(cyc, bad);
    chk("resweep_cycles", cyc, 256);
    chk("resweep_no_rv_err", bad, 0);
    drive(3'd1, 8'hC8, 8'h00, 8'h00); tick();
    chk("cleared_c8_dat", dat_out, 8'h00);
    chk("cleared_c8_rv", rd_valid, 1);
    drive(3'd1, 8'h00, 8'h10, 8'h00); tick();
    chk("cleared_10_dat", dat_out, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dat_mem_stk.md
Name: dat_mem_stk

Overview:
- Parametrised successor to the processor's 8-bit data memory.
- Provides base+offset load/store and a hardware stack (push/pop) that occupies the top region of the same array.
- Memory is zero-cleared after reset by an internal sweep state machine.
- Reads are synchronous (registered), replacing the old combinational read path.
- Sits between the core's load/store/stack decode and the ALU writeback mux.

Parameters:
- DW, 8: data word width in bits.
- AW, 8: address width; DEPTH = 2**AW words.
- STK_BASE, 128: lowest word address usable by the stack. Legal range is 1..DEPTH-1, checked by an elaboration assertion.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  3  operation: 0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5-7 reserved.
- addr  in  AW  base address pointer (LOAD/STORE).
- immed  in  AW  offset added to addr (LOAD/STORE).
- dat_in  in  DW  write data (STORE/PUSH).
- dat_out  out  DW  registered read data (LOAD/POP).
- rd_valid  out  1  one-cycle pulse: dat_out updated this cycle.
- busy  out  1  high while the clear sweep runs; op is ignored.
- sp  out  AW  stack pointer (next free slot).
- err  out  1  one-cycle pulse: overflow, underflow or reserved op.

Behaviour:
- Reset (async, any state, including mid-sweep) sets:
  - state = CLEAR, clr_ptr = 0, sp = DEPTH-1;
  - dat_out = 0, rd_valid = 0, err = 0, busy = 1.
- FSM CLEAR:
  - each cycle writes 0 to mem[clr_ptr], then clr_ptr += 1.
  - after the write of address DEPTH-1, state goes to READY and busy drops.
  - first op is accepted DEPTH+1 edges after reset deassertion.
- In CLEAR, op is ignored entirely: no write, no read, no err.
- FSM READY: exactly one op is sampled per rising edge.
- Effective address ea = (addr + immed) truncated to AW bits; wraps modulo DEPTH, with no carry/err.
- LOAD: dat_out <= mem[ea] and rd_valid = 1 on the next edge (1-cycle latency).
- STORE:
  - mem[ea] <= dat_in at the edge; no read response.
  - a LOAD of the same ea in the following cycle returns the new value.
- PUSH:
  - if sp == STK_BASE-1 (full): no write, sp unchanged, err = 1.
  - otherwise mem[sp] <= dat_in and sp <= sp-1.
- POP:
  - if sp == DEPTH-1 (empty): no read, dat_out holds, rd_valid = 0, err = 1.
  - otherwise sp <= sp+1, dat_out <= mem[sp+1], rd_valid = 1.
- Reserved op: acts as NOP with err = 1.
- When no read completes, dat_out holds its last value; rd_valid and err default to 0 each cycle.
- STORE into the stack region is permitted; there is no protection between the two address spaces.
- Stack capacity is DEPTH-STK_BASE words (128 by default).

Decomposition:
- Package dat_mem_pkg:
  - op_t enum (OP_NOP..OP_POP);
  - state_t enum {CLEAR, READY};
  - localparam DEPTH.
- Sub-module dat_mem_ram:
  - DW x DEPTH array, one write port and one synchronous read port;
  - no reset on the array, so it stays inferable as block RAM.
- Top level holds the FSM, sp, address/port muxing and err logic.

Test Plan:
- Reset, then hold op=LOAD addr=0x10 immed=0 through the sweep: busy is 1 for 256 cycles, no rd_valid or err; after busy falls, LOAD returns 0x00 with rd_valid 1 cycle later.
- STORE addr=0xF0 immed=0x20 dat_in=0xA5 (ea wraps to 0x10), then LOAD addr=0x08 immed=0x08: dat_out = 0xA5 one cycle after the LOAD.
- PUSH 0x11, PUSH 0x22, POP, POP: sp goes 255 → 254 → 253 → 254 → 255; dat_out = 0x22 then 0x11 with rd_valid each; a third POP gives err = 1 and dat_out stays 0x11.
- 128 PUSHes (sp = 127), then a 129th PUSH of 0xEE: err = 1, sp = 127, and LOAD 0x7F still returns 0x00.
- Assert reset mid-sweep (clr_ptr = 50) after STORE-ing 0x77 at 0xC8: sweep restarts at 0 and a later LOAD 0xC8 returns 0x00.
- op = 6 in READY: err pulses for one cycle, memory and sp are unchanged, rd_valid stays 0.
